// File: rtl/sram_bank_ifc.sv
// Fabric-to-SRAM bridge for NUM_BANKS single-port OpenRAM macros: bank decode,
// masked/replicated sub-word writes, tracked reads with aligned sub-word return.
module sram_bank_ifc #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BASE_AW   = 9,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned SUB_W    = $clog2(DATA_W),
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned ADDR_W   = BANK_W + SUB_W + BASE_AW,
  localparam int unsigned MAXC     = SUB_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fab_csb,
  input  logic                        fab_web,
  input  logic [ADDR_W-1:0]           fab_addr,
  input  logic [2:0]                  fab_conf,
  input  logic                        fab_sext,
  input  logic [DATA_W-1:0]           fab_wdata,
  input  logic                        out_reg,
  output logic [NUM_BANKS-1:0]        sram_csb,
  output logic                        sram_web,
  output logic [BASE_AW-1:0]          sram_addr,
  output logic [DATA_W-1:0]           sram_din,
  output logic [DATA_W-1:0]           sram_wmask,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout,
  output logic [DATA_W-1:0]           fab_rdata,
  output logic                        fab_rvalid,
  output logic                        addr_err
);

  logic [BANK_W-1:0]    bank;
  logic [SUB_W-1:0]     sub;
  logic [BASE_AW-1:0]   base;
  logic                 bank_ok;
  logic                 acc_ok;
  logic [2:0]           c_eff;
  logic [SUB_W-1:0]     lo_mask;
  logic [SUB_W-1:0]     f_idx;
  logic [NUM_BANKS-1:0] csb_d;
  logic [DATA_W-1:0]    din_d;
  logic [DATA_W-1:0]    wmask_d;

  // S1 request attributes carried toward the read return
  logic                 s1_rd;
  logic [BANK_W-1:0]    s1_bank;
  logic [2:0]           s1_c;
  logic [SUB_W-1:0]     s1_f;
  logic                 s1_sext;

  // track register: describes the read whose data is on sram_dout now
  logic                 trk_rd;
  logic [BANK_W-1:0]    trk_bank;
  logic [2:0]           trk_c;
  logic [SUB_W-1:0]     trk_f;
  logic                 trk_sext;

  logic                 rvalid_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    bank_dout;
  logic [SUB_W-1:0]     trk_mask;
  logic [DATA_W-1:0]    shifted;
  logic                 sign_bit;
  logic [DATA_W-1:0]    field_c;

  assign {bank, sub, base} = fab_addr;
  assign bank_ok = {1'b0, bank} < (BANK_W + 1)'(NUM_BANKS);
  assign acc_ok  = !fab_csb && bank_ok;
  assign c_eff   = (fab_conf > 3'(MAXC)) ? 3'(MAXC) : fab_conf;
  assign lo_mask = ~({SUB_W{1'b1}} << c_eff);
  assign f_idx   = sub >> c_eff;

  // bank select, replicated write data and field write mask
  always_comb begin
    csb_d   = '1;
    din_d   = '0;
    wmask_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (acc_ok && (bank == BANK_W'(b))) csb_d[b] = 1'b0;
    end
    for (int i = 0; i < DATA_W; i++) begin
      din_d[i]   = fab_wdata[SUB_W'(i) & lo_mask];
      wmask_d[i] = acc_ok && !fab_web && ((SUB_W'(i) >> c_eff) == f_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb   <= '1;
      sram_web   <= 1'b1;
      sram_addr  <= '0;
      sram_din   <= '0;
      sram_wmask <= '0;
      addr_err   <= 1'b0;
      s1_rd      <= 1'b0;
      s1_bank    <= '0;
      s1_c       <= '0;
      s1_f       <= '0;
      s1_sext    <= 1'b0;
    end else begin
      sram_csb   <= csb_d;
      sram_web   <= fab_web;
      sram_addr  <= base;
      sram_din   <= din_d;
      sram_wmask <= wmask_d;
      addr_err   <= !fab_csb && !bank_ok;
      s1_rd      <= acc_ok && fab_web;
      s1_bank    <= bank;
      s1_c       <= c_eff;
      s1_f       <= f_idx;
      s1_sext    <= fab_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_rd   <= 1'b0;
      trk_bank <= '0;
      trk_c    <= '0;
      trk_f    <= '0;
      trk_sext <= 1'b0;
    end else begin
      trk_rd   <= s1_rd;
      trk_bank <= s1_bank;
      trk_c    <= s1_c;
      trk_f    <= s1_f;
      trk_sext <= s1_sext;
    end
  end

  // pick the tracked bank's word and extract/extend the aligned field
  always_comb begin
    bank_dout = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (trk_bank == BANK_W'(b)) bank_dout = sram_dout[b*DATA_W +: DATA_W];
    end
    trk_mask = ~({SUB_W{1'b1}} << trk_c);
    shifted  = bank_dout >> (trk_f << trk_c);
    sign_bit = trk_sext && shifted[trk_mask];
    field_c  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      field_c[i] = ((SUB_W'(i) & ~trk_mask) == '0) ? shifted[i] : sign_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= trk_rd;
      if (trk_rd) rdata_q <= field_c;
    end
  end

  // unregistered mode shows the live field only while its strobe is up
  assign fab_rvalid = out_reg ? rvalid_q : trk_rd;
  assign fab_rdata  = (out_reg || !trk_rd) ? rdata_q : field_c;

endmodule

// File: tb/tb_sram_bank_ifc.sv
// Self-checking bench for sram_bank_ifc: directed scenarios plus randomized
// traffic against a shadow-memory model, with a simple OpenRAM-style macro model.
module tb_sram_bank_ifc;
  localparam int unsigned DW  = 32;
  localparam int unsigned BAW = 9;
  localparam int unsigned NB  = 3;
  localparam int unsigned AW  = 2 + 5 + BAW;

  typedef struct {
    bit          csb;
    bit          web;
    int          bank;
    int          sub;
    int          base;
    int          conf;
    bit          sext;
    logic [31:0] wdata;
  } req_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fab_csb = 1'b1;
  logic             fab_web = 1'b1;
  logic [AW-1:0]    fab_addr = '0;
  logic [2:0]       fab_conf = '0;
  logic             fab_sext = 1'b0;
  logic [DW-1:0]    fab_wdata = '0;
  logic             out_reg = 1'b0;
  logic [NB-1:0]    sram_csb;
  logic             sram_web;
  logic [BAW-1:0]   sram_addr;
  logic [DW-1:0]    sram_din;
  logic [DW-1:0]    sram_wmask;
  logic [NB*DW-1:0] sram_dout;
  logic [DW-1:0]    fab_rdata;
  logic             fab_rvalid;
  logic             addr_err;

  int checks = 0;
  int errors = 0;
  int tick = 0;

  logic [DW-1:0] ram    [NB][512];
  logic [DW-1:0] shadow [NB][512];
  logic [DW-1:0] dout_r [NB];
  bit            ev [16];
  logic [31:0]   ed [16];
  logic [31:0]   last_rd;
  bit            last_known;

  sram_bank_ifc #(.DATA_W(DW), .BASE_AW(BAW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .fab_csb(fab_csb), .fab_web(fab_web),
    .fab_addr(fab_addr), .fab_conf(fab_conf), .fab_sext(fab_sext),
    .fab_wdata(fab_wdata), .out_reg(out_reg), .sram_csb(sram_csb),
    .sram_web(sram_web), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_wmask(sram_wmask), .sram_dout(sram_dout), .fab_rdata(fab_rdata),
    .fab_rvalid(fab_rvalid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // single-port macros: masked write or read into a dout register each edge
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!sram_csb[b]) begin
        if (!sram_web)
          ram[b][sram_addr] <= (ram[b][sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
        else
          dout_r[b] <= ram[b][sram_addr];
      end
    end
  end
  assign sram_dout = {dout_r[2], dout_r[1], dout_r[0]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (tick %0d)", tag, got, exp, tick);
    end
  endtask

  function automatic req_t mk(bit csb, bit web, int bank, int sub, int base,
                              int conf, bit sext, logic [31:0] wdata);
    req_t r;
    r.csb = csb; r.web = web; r.bank = bank; r.sub = sub; r.base = base;
    r.conf = conf; r.sext = sext; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t idle();
    return mk(1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 32'h0);
  endfunction

  // drive one request, step one edge, check S1 outputs and the read return
  task automatic cycle(input req_t r);
    int          w, off, lat, ce;
    longint      m;
    bit          valid;
    logic [31:0] word, fld, e_din, e_mask;
    logic [2:0]  e_csb;
    fab_csb   = r.csb;
    fab_web   = r.web;
    fab_addr  = {2'(r.bank), 5'(r.sub), 9'(r.base)};
    fab_conf  = 3'(r.conf);
    fab_sext  = r.sext;
    fab_wdata = r.wdata;
    ce    = (r.conf > 5) ? 5 : r.conf;
    w     = 1 << ce;
    off   = (r.sub / w) * w;
    m     = (longint'(1) << w) - 1;
    valid = !r.csb && (r.bank < NB);
    e_csb = valid ? 3'(7 & ~(1 << r.bank)) : 3'b111;
    e_din = '0;
    for (int j = 0; j < DW; j += w) e_din = e_din | 32'((longint'(r.wdata) & m) << j);
    e_mask = (valid && !r.web) ? 32'(m << off) : 32'h0;
    if (valid) begin
      word = shadow[r.bank][r.base];
      if (r.web) begin
        fld = 32'((longint'(word) >> off) & m);
        if (r.sext && fld[w-1]) fld = fld | ~32'(m);
        lat = out_reg ? 3 : 2;
        ev[(tick + lat) % 16] = 1'b1;
        ed[(tick + lat) % 16] = fld;
      end else begin
        shadow[r.bank][r.base] =
          32'((longint'(word) & ~(m << off)) | ((longint'(r.wdata) & m) << off));
      end
    end
    @(posedge clk);
    #1;
    tick++;
    chk("csb", 64'(sram_csb), 64'(e_csb));
    chk("web", 64'(sram_web), 64'(r.web));
    chk("addr", 64'(sram_addr), 64'(r.base));
    chk("din", 64'(sram_din), 64'(e_din));
    chk("wmask", 64'(sram_wmask), 64'(e_mask));
    chk("addr_err", 64'(addr_err), 64'(!r.csb && (r.bank >= NB)));
    chk("rvalid", 64'(fab_rvalid), 64'(ev[tick % 16]));
    if (ev[tick % 16]) begin
      chk("rdata", 64'(fab_rdata), 64'(ed[tick % 16]));
      if (out_reg) begin
        last_rd    = ed[tick % 16];
        last_known = 1'b1;
      end
    end else if (out_reg && last_known) begin
      chk("rdata_hold", 64'(fab_rdata), 64'(last_rd));
    end
    ev[tick % 16] = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(idle());
  endtask

  initial begin
    req_t r;
    for (int b = 0; b < NB; b++) begin
      dout_r[b] = '0;
      for (int a = 0; a < 512; a++) begin
        ram[b][a]    = '0;
        shadow[b][a] = '0;
      end
    end
    for (int k = 0; k < 16; k++) begin
      ev[k] = 1'b0;
      ed[k] = '0;
    end
    last_rd    = '0;
    last_known = 1'b0;

    #12;
    chk("rst_csb", 64'(sram_csb), 64'h7);
    chk("rst_web", 64'(sram_web), 64'h1);
    chk("rst_addr", 64'(sram_addr), 64'h0);
    chk("rst_din", 64'(sram_din), 64'h0);
    chk("rst_wmask", 64'(sram_wmask), 64'h0);
    chk("rst_rdata", 64'(fab_rdata), 64'h0);
    chk("rst_rvalid", 64'(fab_rvalid), 64'h0);
    chk("rst_addr_err", 64'(addr_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // byte write into bank 0, field 1
    cycle(mk(1'b0, 1'b0, 0, 8, 'h010, 3, 1'b0, 32'h000000A5));
    chk("bw_csb", 64'(sram_csb), 64'h6);
    chk("bw_din", 64'(sram_din), 64'hA5A5A5A5);
    chk("bw_wmask", 64'(sram_wmask), 64'h0000FF00);
    chk("bw_addr", 64'(sram_addr), 64'h010);

    // aligned reads, unregistered path, directly after the write
    cycle(mk(1'b0, 1'b0, 0, 0, 'h020, 5, 1'b0, 32'h1234A5CD));
    cycle(mk(1'b0, 1'b1, 0, 9, 'h020, 3, 1'b0, 32'h0));
    cycle(idle());
    chk("rd8_valid", 64'(fab_rvalid), 64'h1);
    chk("rd8_data", 64'(fab_rdata), 64'h000000A5);
    cycle(mk(1'b0, 1'b1, 0, 9, 'h020, 3, 1'b1, 32'h0));
    cycle(idle());
    chk("rd8s_data", 64'(fab_rdata), 64'hFFFFFFA5);

    // back-to-back reads, registered path
    cycle(mk(1'b0, 1'b0, 1, 0, 'h030, 5, 1'b0, 32'hDEADBEEF));
    drain(4);
    out_reg = 1'b1;
    last_known = 1'b0;
    cycle(mk(1'b0, 1'b1, 1, 0, 'h030, 5, 1'b0, 32'h0));
    cycle(mk(1'b0, 1'b1, 0, 16, 'h020, 4, 1'b0, 32'h0));
    cycle(idle());
    chk("b2b_v0", 64'(fab_rvalid), 64'h1);
    chk("b2b_d0", 64'(fab_rdata), 64'hDEADBEEF);
    cycle(idle());
    chk("b2b_v1", 64'(fab_rvalid), 64'h1);
    chk("b2b_d1", 64'(fab_rdata), 64'h00001234);
    cycle(idle());
    chk("b2b_hold", 64'(fab_rdata), 64'h00001234);
    drain(4);
    out_reg = 1'b0;
    last_known = 1'b0;

    // out-of-range bank followed by a valid read
    cycle(mk(1'b0, 1'b1, 3, 0, 'h020, 5, 1'b0, 32'h0));
    chk("oor_csb", 64'(sram_csb), 64'h7);
    chk("oor_err", 64'(addr_err), 64'h1);
    cycle(mk(1'b0, 1'b1, 0, 0, 'h020, 5, 1'b0, 32'h0));
    chk("oor_err_clr", 64'(addr_err), 64'h0);
    chk("oor_no_rvalid", 64'(fab_rvalid), 64'h0);
    cycle(idle());
    chk("oor_next_v", 64'(fab_rvalid), 64'h1);
    chk("oor_next_d", 64'(fab_rdata), 64'h1234A5CD);
    drain(2);

    // reset between E1 and E2 of a read
    cycle(mk(1'b0, 1'b1, 1, 0, 'h030, 5, 1'b0, 32'h0));
    #2;
    rst_n = 1'b0;
    r = idle();
    fab_csb = r.csb;
    fab_web = r.web;
    #1;
    chk("mrst_csb", 64'(sram_csb), 64'h7);
    chk("mrst_rdata", 64'(fab_rdata), 64'h0);
    chk("mrst_rvalid", 64'(fab_rvalid), 64'h0);
    for (int k = 0; k < 16; k++) ev[k] = 1'b0;
    last_known = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick++;
    drain(4);

    // reserved width code behaves as full word
    cycle(mk(1'b0, 1'b0, 2, 3, 'h005, 7, 1'b0, 32'hCAFEF00D));
    chk("c7_wmask", 64'(sram_wmask), 64'hFFFFFFFF);
    chk("c7_din", 64'(sram_din), 64'hCAFEF00D);

    // randomized traffic in both output modes
    for (int ph = 0; ph < 4; ph++) begin
      drain(4);
      out_reg = ph[0];
      last_known = 1'b0;
      for (int n = 0; n < 200; n++) begin
        r = mk(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), $urandom);
        cycle(r);
      end
    end
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bank_ifc.md
Name: sram_bank_ifc

Overview:
- Parametrised, multi-bank successor of the fabric-to-SRAM interface.
- Sits between an FPGA fabric tile and NUM_BANKS single-port SRAM macros (OpenRAM pinout: active-low csb/web, per-bit wmask, din/dout).
- Accepts a fabric access, decodes the bank, and generates the masked, replicated write word.
- Tracks in-flight reads and returns the selected sub-word field, aligned, with a read-valid strobe and an optional output register.

Parameters:
- DATA_W, 32: SRAM word width; power of 2, 8..128.
- BASE_AW, 9: SRAM macro address width.
- NUM_BANKS, 2: number of SRAM macros, 1..8.
- Derived: SUB_W = clog2(DATA_W); BANK_W = max(1, clog2(NUM_BANKS)); ADDR_W = BANK_W+SUB_W+BASE_AW; MAXC = clog2(DATA_W).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fab_csb  in  1  access request, active low.
- fab_web  in  1  0 = write, 1 = read.
- fab_addr  in  ADDR_W  {bank, subaddr, baseaddr}, MSB to LSB.
- fab_conf  in  3  width code c: field = 2^c bits; codes above MAXC are treated as MAXC.
- fab_sext  in  1  sign-extend read field.
- fab_wdata  in  DATA_W  write field in the low bits.
- out_reg  in  1  1 = registered read path (quasi-static).
- sram_csb  out  NUM_BANKS  per-bank chip select, active low.
- sram_web  out  1  shared write enable, active low.
- sram_addr  out  BASE_AW  shared address.
- sram_din  out  DATA_W  shared write data.
- sram_wmask  out  DATA_W  shared per-bit write mask.
- sram_dout  in  NUM_BANKS*DATA_W  bank b occupies slice [b*DATA_W +: DATA_W].
- fab_rdata  out  DATA_W  read field, right-justified.
- fab_rvalid  out  1  one-cycle strobe: fab_rdata holds a new read.
- addr_err  out  1  one-cycle pulse: bank index >= NUM_BANKS.

Behaviour:
- Reset (async assert, sync deassert):
  - sram_csb all 1; sram_web=1; sram_addr, sram_din, sram_wmask = 0.
  - fab_rdata=0; fab_rvalid=0; addr_err=0.
  - All tracking state is cleared and in-flight reads are discarded, so no rvalid follows.
- Stage S1 (edge E1 samples the fabric inputs; all sram_* outputs are registered):
  - If fab_csb=0 and the bank is in range: sram_csb[bank]=0 and all other bits are 1.
  - If fab_csb=1: all sram_csb bits are 1.
  - If fab_csb=0 and the bank is out of range: all sram_csb bits are 1 and addr_err=1 for exactly that cycle; no rvalid follows.
  - sram_web = fab_web; sram_addr = baseaddr.
  - Field index f = subaddr >> c. Low subaddr bits below the field width are ignored (forced alignment).
  - sram_din = low 2^c bits of fab_wdata replicated across DATA_W.
  - sram_wmask: bits [f*2^c +: 2^c] are 1 when the access is a valid write; otherwise all 0.
- Stage S2 (edge E2; the SRAM latches the S1 outputs on the same edge):
  - Track register captures rd = (valid access and web=1), plus bank, effective c, f and sext.
  - Next-edge updates are not gated by any other condition: back-to-back accesses are allowed every cycle.
- Read return (after E2; sram_dout[bank] is valid after E2):
  - Field = dout[f*2^c +: 2^c], zero-extended, or sign-extended from field bit 2^c-1 when sext=1.
- out_reg=0:
  - fab_rdata/fab_rvalid are driven combinationally from the track register and bank dout during the cycle after E2.
  - Latency is 2 edges.
  - fab_rdata equals the new field only while rvalid=1; otherwise it is undefined-but-stable.
- out_reg=1:
  - The field is registered at E3; fab_rvalid=1 for the cycle after E3.
  - fab_rdata holds its last read value until the next rvalid (3-edge latency).
  - fab_rdata and fab_rvalid are sourced from the same path, so both come from the registered pair when out_reg=1.
- A write followed immediately by a read to the same address returns the new data; the macro orders them and no bypass is needed.
- Changing out_reg while reads are in flight: those reads may lose or duplicate their rvalid. out_reg must only change while idle.

Test Plan:
- Byte write setup: DATA_W=32, BASE_AW=9, NUM_BANKS=2. Request fab_csb=0, web=0, conf=3, addr={bank0, sub=8, base=0x010}, wdata=0x000000A5.
  - After E1: sram_csb=2'b10, web=0, addr=0x010, din=0xA5A5A5A5, wmask=0x0000FF00.
- Aligned read, out_reg=0: read with conf=3, sub=9, bank0; bank0 dout=0x1234A5CD.
  - fab_rvalid=1 in the cycle after E2; fab_rdata=0x000000A5.
  - With sext=1: fab_rdata=0xFFFFFFA5.
- Back-to-back reads, out_reg=1: bank1 (conf=5, dout1=0xDEADBEEF), then bank0 (conf=4, sub=16, dout0=0x1234A5CD).
  - rvalid on two consecutive cycles; data 0xDEADBEEF, then 0x00001234.
- Out-of-range bank: NUM_BANKS=3, read to bank=3.
  - sram_csb=3'b111, addr_err pulses 1 cycle, no rvalid.
  - A valid read issued in the next cycle completes normally.
- Reset mid-read: drop rst_n between E1 and E2 of a read.
  - sram_csb returns to all 1 immediately (asynchronous), fab_rdata=0, and rvalid never asserts after release.
- Reserved code: conf=7 write with DATA_W=32.
  - Treated as 32-bit: wmask=0xFFFFFFFF, din=fab_wdata.
